// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache main-memory arbiter: state encoding,
// grant identifiers and default bus widths.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10,
    DONE    = 2'b11
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  assign gnt_valid = req_i | req_d;
  assign gnt_id    = (req_i & req_d) ? ~last_grant : (req_d ? GNT_D : GNT_I);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and the D-cache with
// round-robin arbitration and a dead cycle after every completed transfer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  arb_state_t state, state_n;
  logic       last_grant, last_grant_n;
  logic       req_i, req_d;
  logic       gnt_valid, gnt_id;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read | d_mem_write;

  // Read data is broadcast; only the ready pulses are steered.
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  rr_arb2 u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state      <= IDLE;
      last_grant <= GNT_I;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_mem_ready  = 1'b0;
    d_mem_ready  = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (gnt_valid) state_n = (gnt_id == GNT_D) ? SERVE_D : SERVE_I;
      end
      SERVE_I: begin
        mem_read = i_mem_read;
        mem_addr = i_mem_addr;
        // A dropped request abandons the grant without touching fairness.
        if (!req_i) state_n = IDLE;
        else if (mem_ready) begin
          i_mem_ready  = 1'b1;
          last_grant_n = GNT_I;
          state_n      = DONE;
        end
      end
      SERVE_D: begin
        mem_write = d_mem_write;
        mem_read  = d_mem_read & ~d_mem_write;
        mem_addr  = d_mem_addr;
        mem_wdata = d_mem_wdata;
        if (!req_d) state_n = IDLE;
        else if (mem_ready) begin
          d_mem_ready  = 1'b1;
          last_grant_n = GNT_D;
          state_n      = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!proc_reset_n) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      i_mem_ready = 1'b0;
      d_mem_ready = 1'b0;
      busy        = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 4-cycle memory model, cache driver tasks
// and a scoreboard monitor that checks every ready pulse against a queue.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         i_mem_read;
  logic [27:0]  i_mem_addr;
  logic [127:0] i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read, d_mem_write;
  logic [27:0]  d_mem_addr;
  logic [127:0] d_mem_wdata, d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic         busy;

  logic         mdl_rdy, stray_rdy;
  int           mdl_cnt;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    bit           d;
    bit           wr;
    logic [27:0]  a;
    logic [127:0] wd;
    logic [127:0] rd;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  // Memory: data is a fixed pattern of the address; ready after 4 request cycles.
  assign mem_rdata = {4{4'h5, mem_addr}};
  assign mem_ready = mdl_rdy | stray_rdy;

  always @(posedge clk) begin
    if ((mem_read || mem_write) && !mdl_rdy) begin
      if (mdl_cnt == 3) begin
        mdl_rdy <= 1'b1;
        mdl_cnt <= 0;
      end else mdl_cnt <= mdl_cnt + 1;
    end else begin
      mdl_rdy <= 1'b0;
      if (!(mem_read || mem_write)) mdl_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for ready", name);
  endtask

  always @(negedge clk) begin
    if (mem_write) chk("read_during_write", mem_read, 0);
    if (i_mem_ready || d_mem_ready) begin
      chk("both_ready", i_mem_ready & d_mem_ready, 0);
      chk("ready_without_mem", mem_ready, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: i=%0b d=%0b expected none", i_mem_ready, d_mem_ready);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_who", d_mem_ready, mon_e.d);
        chk("mem_write", mem_write, mon_e.wr);
        chk("mem_read", mem_read, !mon_e.wr);
        chk("mem_addr", mem_addr, mon_e.a);
        if (mon_e.wr) chk("mem_wdata", mem_wdata, mon_e.wd);
        else chk("rdata", mon_e.d ? d_mem_rdata : i_mem_rdata, mon_e.rd);
      end
    end
  end

  task automatic push(input bit d, input bit wr, input logic [27:0] a,
                      input logic [127:0] wd, input logic [127:0] rd);
    exp_t e;
    e.d = d; e.wr = wr; e.a = a; e.wd = wd; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Requests are held through the DONE cycle to model a stale request.
  task automatic do_i(input logic [27:0] a);
    bit got = 0;
    i_mem_addr = a;
    i_mem_read = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = i_mem_ready;
    end
    if (!got) timeout("i_ready");
    @(posedge clk); @(posedge clk); #1;
    i_mem_read = 1'b0;
    i_mem_addr = '0;
  endtask

  task automatic do_d(input bit wr, input logic [27:0] a, input logic [127:0] wd);
    bit got = 0;
    d_mem_addr  = a;
    d_mem_wdata = wd;
    d_mem_write = wr;
    d_mem_read  = !wr;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = d_mem_ready;
    end
    if (!got) timeout("d_ready");
    @(posedge clk); @(posedge clk); #1;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
  endtask

  task automatic do_reset(input int n);
    proc_reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 proc_reset_n = 1'b1;
  endtask

  initial begin
    proc_reset_n = 1'b0;
    i_mem_read = 0; i_mem_addr = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    stray_rdy = 0;
    mdl_rdy = 0; mdl_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_i_ready", i_mem_ready, 0);
    @(posedge clk); #1 proc_reset_n = 1'b1;

    // I-only refill of block 0x10
    push(0, 0, 28'h0000010, '0, 128'h50000010500000105000001050000010);
    fork
      do_i(28'h0000010);
      begin
        bit got = 0;
        @(negedge clk);
        chk("t1_arb_cycle_read", mem_read, 0);
        @(negedge clk);
        chk("t1_fwd_read", mem_read, 1);
        chk("t1_fwd_addr", mem_addr, 28'h10);
        chk("t1_fwd_wdata", mem_wdata, 0);
        for (int k = 0; k < 60 && !got; k++) begin
          @(negedge clk);
          chk("t1_d_ready", d_mem_ready, 0);
          got = i_mem_ready;
        end
        @(negedge clk);
        chk("t1_done_busy", busy, 1);
        chk("t1_done_read", mem_read, 0);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
      end
    join

    // D write-back of block 0xA4
    push(1, 1, 28'h00000A4, 128'hDEADBEEF_00112233_44556677_8899AABB, '0);
    fork
      do_d(1, 28'h00000A4, 128'hDEADBEEF_00112233_44556677_8899AABB);
      begin
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
          @(negedge clk);
          got = d_mem_ready;
        end
        @(negedge clk);
        chk("t2_stale_write_held", d_mem_write, 1);
        chk("t2_done_mem_write", mem_write, 0);
        chk("t2_done_d_ready", d_mem_ready, 0);
      end
    join

    // Simultaneous requests after reset: D first, then strict alternation
    do_reset(2);
    push(1, 0, 28'h0000200, '0, 128'h50000200500002005000020050000200);
    push(0, 0, 28'h0000100, '0, 128'h50000100500001005000010050000100);
    push(1, 0, 28'h0000300, '0, 128'h50000300500003005000030050000300);
    push(0, 0, 28'h0000180, '0, 128'h50000180500001805000018050000180);
    fork
      begin do_d(0, 28'h0000200, '0); do_d(0, 28'h0000300, '0); end
      begin do_i(28'h0000100); do_i(28'h0000180); end
    join

    // Write-back then refill with an I refill arriving mid write-back
    push(1, 1, 28'h0000040, 128'h0123456789ABCDEF_FEDCBA9876543210, '0);
    push(0, 0, 28'h0000080, '0, 128'h50000080500000805000008050000080);
    push(1, 0, 28'h0000040, '0, 128'h50000040500000405000004050000040);
    fork
      begin
        do_d(1, 28'h0000040, 128'h0123456789ABCDEF_FEDCBA9876543210);
        do_d(0, 28'h0000040, '0);
      end
      begin repeat (2) @(posedge clk); #1; do_i(28'h0000080); end
    join

    // Reset in the middle of a D refill, then a stray memory ready
    d_mem_addr = 28'h0000055;
    d_mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_serving", mem_read, 1);
    @(posedge clk); @(posedge clk); #1;
    proc_reset_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_read", mem_read, 0);
    chk("t5_rst_write", mem_write, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_d_ready", d_mem_ready, 0);
    chk("t5_rst_busy", busy, 0);
    d_mem_read = 1'b0;
    d_mem_addr = '0;
    @(posedge clk); #1 proc_reset_n = 1'b1;
    @(negedge clk);
    chk("t5_post_busy", busy, 0);
    @(posedge clk); #1 stray_rdy = 1'b1;
    @(negedge clk);
    chk("t5_stray_d_ready", d_mem_ready, 0);
    chk("t5_stray_i_ready", i_mem_ready, 0);
    chk("t5_stray_busy", busy, 0);
    @(posedge clk); #1 stray_rdy = 1'b0;
    @(negedge clk);
    chk("t5_after_stray_busy", busy, 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit main-memory port between the I-cache (read-only refills) and the D-cache (refills and write-backs) of the RISC-V pipeline.
- Each cache keeps its existing mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready interface unchanged.
- Arbitration is round-robin on simultaneous requests, with one dead cycle after every completed transaction so that a stale, still-asserted request is not re-granted.

Parameters:
ADDR_W, 28, memory block address width (word address >> 2)
DATA_W, 128, memory block data width

Ports:
clk  input  1  system clock, all state on rising edge
proc_reset_n  input  1  reset; synchronous, active-low
i_mem_read  input  1  I-cache read request, held until i_mem_ready
i_mem_addr  input  ADDR_W  I-cache block address
i_mem_rdata  output  DATA_W  read data to I-cache
i_mem_ready  output  1  completion pulse to I-cache
d_mem_read  input  1  D-cache read request
d_mem_write  input  1  D-cache write request
d_mem_addr  input  ADDR_W  D-cache block address
d_mem_wdata  input  DATA_W  D-cache write data
d_mem_rdata  output  DATA_W  read data to D-cache
d_mem_ready  output  1  completion pulse to D-cache
mem_read  output  1  read request to memory
mem_write  output  1  write request to memory
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
mem_ready  input  1  memory completion, one-cycle pulse
busy  output  1  1 when state != IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (proc_reset_n).
- Reset: on a clk edge with proc_reset_n=0, state<=IDLE and last_grant<=I. While proc_reset_n=0, mem_read, mem_write, i_mem_ready, d_mem_ready and busy are forced to 0 combinationally. mem_addr and mem_wdata are 0.
- Requests: req_i = i_mem_read; req_d = d_mem_read | d_mem_write.
- States: IDLE, SERVE_I, SERVE_D, DONE. busy=1 in SERVE_I, SERVE_D and DONE.
- IDLE:
  - No memory outputs asserted.
  - Only req_i -> SERVE_I. Only req_d -> SERVE_D. Both -> the requester != last_grant. Neither -> stay.
  - Arbitration latency is 1 cycle: a request first seen in cycle N is forwarded to memory in cycle N+1.
- SERVE_x:
  - mem_addr, mem_wdata, mem_read and mem_write are driven combinationally from the granted requester's live signals.
  - The I grant forces mem_write=0 and mem_wdata=0.
  - If d_mem_read and d_mem_write are both 1, the write wins: mem_write=1, mem_read=0.
  - On mem_ready=1: x_mem_ready=1 in the same cycle, last_grant<=x, next state DONE.
  - If the granted requester drops its request before mem_ready: mem_* deassert that cycle (they follow the requester) and next state is IDLE. last_grant is unchanged.
- DONE: exactly 1 cycle. All mem_* are 0 and both readies are 0. Requests are ignored. Next state IDLE.
- Read data: i_mem_rdata and d_mem_rdata both equal mem_rdata at all times (broadcast). Only the ready pulses are gated per requester.
- Ungranted ready: the non-granted ready is always 0. A mem_ready seen in IDLE or DONE is ignored and produces no ready pulse.
- Write-back/refill sequence: a D-cache write-back followed by a refill is two separate grants. An I request pending at the write-back's completion wins the next arbitration, giving fairness.
- Starvation bound: with both requesting continuously, grants strictly alternate. Worst-case wait is one transaction plus 2 cycles.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE=2'b00, SERVE_I=2'b01, SERVE_D=2'b10, DONE=2'b11
  - grant IDs: GNT_I=1'b0, GNT_D=1'b1
  - ADDR_W/DATA_W defaults
- Sub-module rr_arb2: combinational two-requester round-robin picker (inputs req_i, req_d, last_grant; outputs gnt_valid, gnt_id). Used in IDLE.

Test Plan:
- Memory model latency 4 cycles. I-only read to addr 28'h0000010 -> mem_read=1 and mem_addr=0x10 from cycle N+1. i_mem_ready=1 exactly on the mem_ready cycle with i_mem_rdata=model data. d_mem_ready stays 0. busy=0 two cycles later.
- D write to 28'h00000A4 with wdata=128'hDEAD... -> mem_write=1 with the forwarded address and data. mem_read=0 throughout. d_mem_ready pulses once. The following DONE cycle shows mem_write=0 even though d_mem_write is still 1.
- I and D assert in the same cycle straight after reset -> D granted first (last_grant=I). I granted immediately after DONE. Continuous requests alternate D,I,D,I over 4 transactions.
- D write-back then refill, with an I request pending -> grant order D(write), I(read), D(read). No ready pulse goes to the wrong requester.
- proc_reset_n=0 during SERVE_D (2 cycles into latency) -> mem_read/mem_write/readies are 0 while reset is low. After release, state is IDLE, busy=0, and a stray mem_ready is ignored.
